// File: rtl/bitwise_pkg.sv
// Shared definitions for the bitwise controller and its instruction queue:
// opcode constants, sequencer state encoding, queue entry layout and the
// default queue depth.
package bitwise_pkg;

  // Opcode field (upper two bits of an instruction)
  localparam logic [1:0] MOV = 2'b00;
  localparam logic [1:0] XOR = 2'b01;
  localparam logic [1:0] ASL = 2'b10;
  localparam logic [1:0] SWP = 2'b11;

  // Default number of queued instructions (power of two, at least 2)
  localparam int IQ_DEPTH = 4;

  // Issue sequencer states
  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_WAIT  = 2'd2
  } seq_state_e;

  // One queued instruction: {opcode, Rn} plus its immediate operand
  typedef struct packed {
    logic [3:0] op;
    logic [7:0] imm;
  } iq_entry_t;

  // Builds the 4-bit instruction field from opcode and register number
  function automatic logic [3:0] make_op(input logic [1:0] opcode, input logic [1:0] rn);
    return {opcode, rn};
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Instruction storage for instr_queue: circular buffer with wrapping
// read/write pointers, an occupancy counter and full/empty flags.
// A write while full is dropped even if a read happens in the same cycle.
module instr_fifo
  import bitwise_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en_i,
  input  iq_entry_t                wr_data_i,
  input  logic                     rd_en_i,
  output iq_entry_t                head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  iq_entry_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            wr_ok;
  logic            rd_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Fullness is judged before any same-cycle read, so a push into a full
  // queue is always lost.
  assign wr_ok = wr_en_i && !full_o;
  assign rd_ok = rd_en_i && !empty_o;

  // Head is read combinationally so it is valid whenever the queue is non-empty
  assign head_o = mem_q[rd_ptr_q];

  // Next pointer and count values; pointers wrap naturally as DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/instr_queue.sv
// Instruction queue and issue sequencer in front of the bitwise controller.
// Entries are issued strictly in push order: IDLE -> ISSUE (one cycle) ->
// WAIT until a rising edge of done, which pops the head entry.
// Optional feature: define INSTR_QUEUE_OVF_EN to add a sticky ovf output
// that flags any push dropped because the queue was full.
module instr_queue
  import bitwise_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [3:0]               push_op,
  input  logic [7:0]               push_in,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     s,
  output logic [3:0]               issue_op,
  output logic [7:0]               issue_in,
  input  logic                     done,
  output logic                     busy
`ifdef INSTR_QUEUE_OVF_EN
  ,
  output logic                     ovf
`endif
);

  seq_state_e  state_q, state_d;
  logic        s_q, s_d;
  logic        done_q;
  logic        complete;
  iq_entry_t   push_entry;
  iq_entry_t   head;

  assign push_entry = {push_op, push_in};

  instr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en_i   (push),
    .wr_data_i (push_entry),
    .rd_en_i   (complete),
    .head_o    (head),
    .full_o    (full),
    .empty_o   (empty),
    .count_o   (count)
  );

  // Only a fresh rising edge of done while waiting completes the instruction;
  // a level left high from earlier is ignored.
  assign complete = (state_q == SEQ_WAIT) && done && !done_q;

  // State, start-pulse and done-history registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEQ_IDLE;
      s_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      done_q  <= done;
    end
  end

  // Next-state logic of the issue sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_IDLE:  if (!empty) state_d = SEQ_ISSUE;
      SEQ_ISSUE: state_d = SEQ_WAIT;
      SEQ_WAIT:  if (complete) state_d = SEQ_IDLE;
      default:   state_d = SEQ_IDLE;
    endcase
  end

  // Outputs: start pulse registered from ISSUE, head entry shown while busy
  always_comb begin
    s_d      = 1'b0;
    busy     = 1'b0;
    issue_op = '0;
    issue_in = '0;
    if (state_q == SEQ_ISSUE) begin
      s_d = 1'b1;
    end
    if (state_q != SEQ_IDLE) begin
      busy     = 1'b1;
      issue_op = head.op;
      issue_in = head.imm;
    end
  end

  assign s = s_q;

`ifdef INSTR_QUEUE_OVF_EN
  logic ovf_q;

  // Sticky record of any push lost to a full queue
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (push && full) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_instr_queue.sv
// Directed scoreboard bench for instr_queue. Expected entries are queued as
// they are pushed and compared when an s pulse is observed.
module tb_instr_queue;
  import bitwise_pkg::*;

  localparam int DEPTH = IQ_DEPTH;

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic       push     = 1'b0;
  logic [3:0] push_op  = '0;
  logic [7:0] push_in  = '0;
  logic       done     = 1'b0;
  logic       full, empty, s, busy;
  logic [$clog2(DEPTH):0] count;
  logic [3:0] issue_op;
  logic [7:0] issue_in;
`ifdef INSTR_QUEUE_OVF_EN
  logic       ovf;
`endif

  int checks      = 0;
  int failures    = 0;
  int s_pulses    = 0;
  int exp_pulses  = 0;
  int model_count = 0;
  iq_entry_t expq[$];
  iq_entry_t mon_e;

  always #5 clk = ~clk;

  instr_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_op  (push_op),
    .push_in  (push_in),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .s        (s),
    .issue_op (issue_op),
    .issue_in (issue_in),
    .done     (done),
    .busy     (busy)
`ifdef INSTR_QUEUE_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Push one entry; the model accepts it only if the queue has room
  task automatic push_entry(input logic [3:0] op, input logic [7:0] imm);
    push    = 1'b1;
    push_op = op;
    push_in = imm;
    if (model_count < DEPTH) begin
      expq.push_back({op, imm});
      model_count++;
    end
    step(1);
    push = 1'b0;
  endtask

  task automatic wait_pulses(input int target);
    int g = 0;
    while (s_pulses < target && g < 60) begin
      step(1);
      g++;
    end
    check("s_wait", 32'(s_pulses >= target), 1);
  endtask

  // Wait for the next issue, then raise done three cycles after s
  task automatic run_one();
    exp_pulses++;
    wait_pulses(exp_pulses);
    step(2);
    done = 1'b1;
    step(1);
    done = 1'b0;
    model_count--;
    check("busy_after_done", 32'(busy), 0);
    check("count_after_done", 32'(count), 32'(model_count));
  endtask

  // Scoreboard: every s pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (s === 1'b1) begin
      s_pulses++;
      check("s_pending", 32'(expq.size() > 0), 1);
      if (expq.size() > 0) begin
        mon_e = expq.pop_front();
        check("issue_op", 32'(issue_op), 32'(mon_e.op));
        check("issue_in", 32'(issue_in), 32'(mon_e.imm));
        check("busy_at_s", 32'(busy), 1);
        $display("issue op=%h in=%0d", issue_op, issue_in);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state while reset_n is low, before any clock edge
    #3;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_s", 32'(s), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_issue_op", 32'(issue_op), 0);
    check("rst_issue_in", 32'(issue_in), 0);
`ifdef INSTR_QUEUE_OVF_EN
    check("rst_ovf", 32'(ovf), 0);
`endif
    step(2);
    reset_n = 1'b1;
    step(1);

    // Single MOV R1,42: exact issue latency and hold until done rises
    push_entry(make_op(MOV, 2'd1), 8'd42);
    check("a_count", 32'(count), 1);
    check("a_busy_idle", 32'(busy), 0);
    step(1);
    check("a_s_early", 32'(s), 0);
    check("a_busy_issue", 32'(busy), 1);
    step(1);
    check("a_s_pulse", 32'(s), 1);
    check("a_issue_op", 32'(issue_op), 32'h1);
    check("a_issue_in", 32'(issue_in), 42);
    exp_pulses++;
    step(3);
    check("a_s_single", 32'(s), 0);
    check("a_busy_wait", 32'(busy), 1);
    check("a_op_hold", 32'(issue_op), 32'h1);
    done = 1'b1;
    step(1);
    done = 1'b0;
    model_count--;
    check("a_busy_done", 32'(busy), 0);
    check("a_empty_done", 32'(empty), 1);
    step(1);

    // Five pushes with done low: fifth is dropped
    for (int i = 0; i < 5; i++) begin
      push_entry(make_op(ASL, 2'd0), 8'(8'h10 + i));
    end
    check("b_count_full", 32'(count), 4);
    check("b_full", 32'(full), 1);
`ifdef INSTR_QUEUE_OVF_EN
    check("b_ovf", 32'(ovf), 1);
`endif
    for (int i = 0; i < 4; i++) begin
      run_one();
    end
    check("b_empty", 32'(empty), 1);

    // Four-instruction program issued in push order
    push_entry(make_op(MOV, 2'd1), 8'd42);
    push_entry(make_op(MOV, 2'd2), 8'd11);
    push_entry(make_op(XOR, 2'd0), 8'h5A);
    push_entry(make_op(SWP, 2'd3), 8'h00);
    for (int i = 0; i < 4; i++) begin
      run_one();
    end
    check("c_empty", 32'(empty), 1);
    check("c_busy", 32'(busy), 0);
    check("c_pulses", 32'(s_pulses), 32'(exp_pulses));

    // Push coinciding with completion at count=2
    push_entry(make_op(MOV, 2'd1), 8'd1);
    push_entry(make_op(MOV, 2'd2), 8'd2);
    exp_pulses++;
    wait_pulses(exp_pulses);
    check("d_count_pre", 32'(count), 2);
    push    = 1'b1;
    push_op = make_op(ASL, 2'd2);
    push_in = 8'd3;
    done    = 1'b1;
    expq.push_back({make_op(ASL, 2'd2), 8'd3});
    step(1);
    push = 1'b0;
    done = 1'b0;
    check("d_count_same", 32'(count), 2);
    run_one();
    run_one();
    check("d_empty", 32'(empty), 1);

    // done already high at issue time must not complete the instruction
    done = 1'b1;
    push_entry(make_op(XOR, 2'd3), 8'h77);
    exp_pulses++;
    wait_pulses(exp_pulses);
    step(3);
    check("e_busy_held", 32'(busy), 1);
    done = 1'b0;
    step(1);
    check("e_busy_low", 32'(busy), 1);
    done = 1'b1;
    step(1);
    done = 1'b0;
    model_count--;
    check("e_busy_edge", 32'(busy), 0);
    check("e_empty", 32'(empty), 1);

    // Reset during the s cycle with three entries queued
    push_entry(make_op(MOV, 2'd0), 8'd100);
    push_entry(make_op(MOV, 2'd1), 8'd101);
    push_entry(make_op(MOV, 2'd2), 8'd102);
    check("f_s_before", 32'(s), 1);
    check("f_count_before", 32'(count), 3);
    reset_n = 1'b0;
    #1;
    check("f_count_rst", 32'(count), 0);
    check("f_s_rst", 32'(s), 0);
    check("f_busy_rst", 32'(busy), 0);
    check("f_empty_rst", 32'(empty), 1);
    check("f_op_rst", 32'(issue_op), 0);
    expq.delete();
    model_count = 0;
    step(2);
    reset_n = 1'b1;
    step(10);
    check("f_no_reissue", 32'(s_pulses), 32'(exp_pulses));
    check("f_busy_after", 32'(busy), 0);
`ifdef INSTR_QUEUE_OVF_EN
    check("f_ovf_cleared", 32'(ovf), 0);
`endif
    check("sb_drained", 32'(expq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
